// File: rtl/game_round_timer.sv
// Round countdown timer for the main game FSM.
// Arms on entry to GAME, counts whole seconds down from a loaded budget with
// pause support, and fires a single end_of_time pulse at expiry.
// Optional feature macro: GAME_TIMER_BONUS_EN adds bonus_valid/bonus_sec inputs
// that top up the remaining time (saturating) while a round is in progress.
module game_round_timer #(
  parameter int unsigned CYC_PER_MS = 100000,
  parameter int unsigned MS_PER_SEC = 1000,
  parameter int unsigned SEC_W      = 8,
  parameter int unsigned WARN_SEC   = 5,
  parameter logic [1:0]  GAME_CODE  = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_in,
  input  logic [SEC_W-1:0] time_in,
  input  logic             pause,
  output logic [SEC_W-1:0] time_left,
  output logic             warning,
  output logic             running,
  output logic             end_of_time
`ifdef GAME_TIMER_BONUS_EN
  ,
  input  logic             bonus_valid,
  input  logic [SEC_W-1:0] bonus_sec
`endif
);

  // Counter widths; kept at least one bit so degenerate parameters still build.
  localparam int unsigned PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int unsigned MW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StExpired
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [MW-1:0]    ms_q, ms_d;
  logic [SEC_W-1:0] tl_q, tl_d;
  logic             warn_q, warn_d;
  logic             eot_q, eot_d;

  logic             in_game;
  logic             presc_max;
  logic             ms_max;
  logic             advance;
  logic             elapse;
  logic [SEC_W:0]   bonus_add;
  logic [SEC_W:0]   sum;

  assign in_game   = (state_in == GAME_CODE);
  assign presc_max = (presc_q == PW'(CYC_PER_MS - 1));
  assign ms_max    = (ms_q == MW'(MS_PER_SEC - 1));

`ifdef GAME_TIMER_BONUS_EN
  assign bonus_add = bonus_valid ? {1'b0, bonus_sec} : '0;
`else
  assign bonus_add = '0;
`endif

  // Next-state, counter and time_left update logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    tl_d    = tl_q;
    eot_d   = 1'b0;
    advance = 1'b0;
    elapse  = 1'b0;
    sum     = '0;

    if (!in_game) begin
      // Leaving GAME wins over everything, including a coincident expiry.
      state_d = StIdle;
      presc_d = '0;
      ms_d    = '0;
      tl_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tl_d    = time_in;
          presc_d = '0;
          ms_d    = '0;
          if (time_in != '0) begin
            state_d = StRun;
          end else begin
            state_d = StExpired;
            eot_d   = 1'b1;
          end
        end
        StRun, StPaused: begin
          // Pause has priority over a second elapsing on the same edge.
          if (pause) begin
            state_d = StPaused;
          end else begin
            state_d = StRun;
            advance = 1'b1;
            elapse  = presc_max && ms_max;
          end
          // tl_q is always >= 1 here, so the subtraction cannot underflow.
          sum = {1'b0, tl_q} + bonus_add - {{SEC_W{1'b0}}, elapse};
          if (elapse && (sum == '0)) begin
            state_d = StExpired;
            tl_d    = '0;
            eot_d   = 1'b1;
          end else if (sum[SEC_W]) begin
            tl_d = '1;
          end else begin
            tl_d = sum[SEC_W-1:0];
          end
        end
        StExpired: begin
          tl_d = '0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (advance) begin
      if (presc_max) begin
        presc_d = '0;
        ms_d    = ms_max ? '0 : ms_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    warn_d = ((state_d == StRun) || (state_d == StPaused)) && (tl_d != '0) &&
             (32'(tl_d) <= WARN_SEC);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      ms_q    <= '0;
      tl_q    <= '0;
      warn_q  <= 1'b0;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      tl_q    <= tl_d;
      warn_q  <= warn_d;
      eot_q   <= eot_d;
    end
  end

  assign time_left   = tl_q;
  assign warning     = warn_q;
  assign end_of_time = eot_q;
  assign running     = (state_q == StRun);

endmodule

// File: tb/tb_game_round_timer.sv
// Scoreboard bench for game_round_timer: a driver issues one stimulus per cycle and
// pushes the reference model's expected outputs; a monitor pops and compares them.
module tb_game_round_timer;

  localparam int unsigned CYC_PER_MS = 4;
  localparam int unsigned MS_PER_SEC = 5;
  localparam int unsigned SEC_W      = 8;
  localparam int unsigned WARN_SEC   = 2;
  localparam logic [1:0]  GAME       = 2'b10;
  localparam int          CPS        = CYC_PER_MS * MS_PER_SEC;
  localparam int          SAT        = (1 << SEC_W) - 1;
`ifdef GAME_TIMER_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       state_in;
  logic [SEC_W-1:0] time_in;
  logic             pause;
  logic [SEC_W-1:0] time_left;
  logic             warning;
  logic             running;
  logic             end_of_time;
`ifdef GAME_TIMER_BONUS_EN
  logic             bonus_valid;
  logic [SEC_W-1:0] bonus_sec;
`endif

  always #5 clk = ~clk;

  game_round_timer #(
    .CYC_PER_MS (CYC_PER_MS),
    .MS_PER_SEC (MS_PER_SEC),
    .SEC_W      (SEC_W),
    .WARN_SEC   (WARN_SEC),
    .GAME_CODE  (GAME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state_in    (state_in),
    .time_in     (time_in),
    .pause       (pause),
    .time_left   (time_left),
    .warning     (warning),
    .running     (running),
    .end_of_time (end_of_time)
`ifdef GAME_TIMER_BONUS_EN
    ,
    .bonus_valid (bonus_valid),
    .bonus_sec   (bonus_sec)
`endif
  );

  typedef struct {
    logic [SEC_W-1:0] tl;
    logic             warn;
    logic             run;
    logic             eot;
    string            tag;
    int               cyc;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  me;
  int    checks   = 0;
  int    failures = 0;
  int    cyc_no   = 0;
  string tag      = "reset";

  // Reference model: a round is either idle, in progress (maybe paused) or done.
  bit m_armed, m_paused, m_done;
  int m_left, m_phase;

  task automatic tick(input bit r, input logic [1:0] st, input int tin, input bit p,
                      input bit bv, input int bs);
    exp_t e;
    int   v;
    int   badd;
    bit   sec;
    bit   eot;
    @(negedge clk);
    rst      = r;
    state_in = st;
    time_in  = SEC_W'(tin);
    pause    = p;
`ifdef GAME_TIMER_BONUS_EN
    bonus_valid = bv;
    bonus_sec   = SEC_W'(bs);
`endif
    badd = (BONUS_ON && bv) ? bs : 0;
    eot  = 1'b0;
    if (r || st != GAME) begin
      m_armed = 0; m_paused = 0; m_done = 0; m_left = 0; m_phase = 0;
    end else if (!m_armed && !m_done) begin
      m_left = tin; m_phase = 0; m_paused = 0;
      if (tin == 0) begin m_done = 1; eot = 1; end
      else m_armed = 1;
    end else if (m_armed) begin
      sec = 0;
      if (p) m_paused = 1;
      else begin
        m_paused = 0;
        m_phase++;
        if (m_phase == CPS) begin sec = 1; m_phase = 0; end
      end
      v = m_left + badd - (sec ? 1 : 0);
      if (v > SAT) v = SAT;
      if (sec && v == 0) begin
        m_left = 0; m_armed = 0; m_done = 1; eot = 1;
      end else m_left = v;
    end
    e.tl   = SEC_W'(m_left);
    e.warn = m_armed && m_left >= 1 && m_left <= int'(WARN_SEC);
    e.run  = m_armed && !m_paused;
    e.eot  = eot;
    e.tag  = tag;
    e.cyc  = cyc_no;
    cyc_no++;
    exp_q.push_back(e);
  endtask

  // Plain GAME cycles with don't-care time_in.
  task automatic run_game(input int n, input bit p);
    for (int i = 0; i < n; i++) tick(0, GAME, int'($urandom_range(0, 255)), p, 0, 0);
  endtask

  task automatic leave(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'b00, int'($urandom_range(0, 255)), 0, 0, 0);
  endtask

  // Monitor: compares one expected entry per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      checks++;
      if ({time_left, warning, running, end_of_time} !== {me.tl, me.warn, me.run, me.eot}) begin
        failures++;
        $display("FAIL %s cyc=%0d: got tl=%0d warn=%0b run=%0b eot=%0b, want tl=%0d warn=%0b run=%0b eot=%0b",
                 me.tag, me.cyc, time_left, warning, running, end_of_time,
                 me.tl, me.warn, me.run, me.eot);
      end
    end
  end

  initial begin
    rst = 1'b1; state_in = 2'b00; time_in = '0; pause = 1'b0;
`ifdef GAME_TIMER_BONUS_EN
    bonus_valid = 1'b0; bonus_sec = '0;
`endif
    tick(1, 2'b00, 0, 0, 0, 0);
    tick(1, GAME, 7, 1, 0, 0);
    tag = "idle"; leave(3);

    tag = "basic";
    tick(0, GAME, 3, 0, 0, 0);
    run_game(160, 0);
    leave(2);

    tag = "pause";
    tick(0, GAME, 2, 0, 0, 0);
    run_game(9, 0);
    run_game(30, 1);
    run_game(40, 0);
    leave(2);

    tag = "exit_mid";
    tick(0, GAME, 5, 0, 0, 0);
    run_game(49, 0);
    leave(1);
    tag = "reenter";
    tick(0, GAME, 1, 0, 0, 0);
    run_game(25, 0);
    leave(2);

    tag = "zero";
    tick(0, GAME, 0, 0, 0, 0);
    run_game(5, 0);
    leave(1);

    tag = "rst_mid";
    tick(0, GAME, 4, 0, 0, 0);
    run_game(10, 0);
    tick(1, GAME, 9, 0, 0, 0);
    leave(2);
    tick(0, GAME, 1, 0, 0, 0);
    run_game(22, 0);
    leave(1);

    tag = "pause_on_expiry";
    tick(0, GAME, 1, 0, 0, 0);
    run_game(19, 0);
    run_game(4, 1);
    run_game(3, 0);
    leave(1);

    tag = "exit_on_expiry";
    tick(0, GAME, 1, 0, 0, 0);
    run_game(19, 0);
    leave(2);
    run_game(1, 0);
    leave(1);

    if (BONUS_ON) begin
      tag = "bonus";
      tick(0, GAME, 1, 0, 0, 0);
      run_game(18, 0);
      tick(0, GAME, 0, 0, 1, 3);
      run_game(65, 0);
      leave(1);
      tag = "bonus_sat";
      tick(0, GAME, 250, 0, 0, 0);
      tick(0, GAME, 0, 0, 1, 10);
      run_game(3, 0);
      tick(0, GAME, 0, 1, 1, 7);
      leave(1);
    end

    tag = "random";
    for (int i = 0; i < 1200; i++) begin
      bit         r;
      logic [1:0] st;
      int         tin;
      bit         p;
      bit         bv;
      int         bs;
      r   = ($urandom_range(0, 249) == 0);
      st  = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : GAME;
      tin = ($urandom_range(0, 9) == 0) ? int'($urandom_range(248, 255))
                                        : int'($urandom_range(0, 2));
      p   = ($urandom_range(0, 5) == 0);
      bv  = ($urandom_range(0, 11) == 0);
      bs  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255))
                                        : int'($urandom_range(0, 3));
      tick(r, st, tin, p, bv, bs);
    end

    tag = "drain";
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
